// File: rtl/kvs_pkg.sv
// Shared definitions for the KVS front-end: key/flag geometry, protocol
// constants, parser FSM states and the flow-key payload layout.
package kvs_pkg;

    localparam int unsigned KEY_SIZE   = 96;
    localparam int unsigned FLAG_SIZE  = 4;

    localparam int unsigned FLAG_TCP    = 0;
    localparam int unsigned FLAG_UDP    = 1;
    localparam int unsigned FLAG_SYN    = 2;
    localparam int unsigned FLAG_FINRST = 3;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_TCP  = 8'd6;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam logic [7:0]  IP_VER_IHL_5  = 8'h45;

    localparam int unsigned BEAT_CNT_W    = 3;
    localparam logic [BEAT_CNT_W-1:0] HDR_LAST_BEAT = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_SKIP = 2'd2
    } state_t;

    // Flow key as presented to db_top: src IP, dst IP, src port, dst port.
    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
    } flow_key_t;

    // Byte i (0 = first on the wire) of a 64-bit stream beat.
    function automatic logic [7:0] beat_byte(input logic [63:0] data, input int unsigned idx);
        return data[8*idx +: 8];
    endfunction

endpackage

// File: rtl/eth_key_extract.sv
// Passive IPv4 TCP/UDP flow-key extractor on a 64-bit receive AXI-Stream.
// Emits one key/flag strobe per eligible frame and counts keys and drops.
module eth_key_extract #(
    parameter int unsigned KEY_SIZE  = 96,
    parameter int unsigned FLAG_SIZE = 4,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [63:0]          s_axis_tdata,
    input  logic [7:0]           s_axis_tkeep,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic [KEY_SIZE-1:0]  in_key,
    output logic [FLAG_SIZE-1:0] in_flag,
    output logic                 in_valid,
    output logic [CNT_WIDTH-1:0] stat_key_cnt,
    output logic [CNT_WIDTH-1:0] stat_drop_cnt
);

    import kvs_pkg::*;

    state_t                  state, state_d;
    logic [BEAT_CNT_W-1:0]   beat_cnt, beat_cnt_d;
    logic                    key_fire;
    logic                    drop_fire;

    logic [15:0] eth_type;
    logic [7:0]  ver_ihl;
    logic [13:0] frag;       // MF bit plus 13-bit fragment offset
    logic [7:0]  proto;
    logic [31:0] src_ip;
    logic [15:0] dst_ip_hi;
    logic [15:0] dst_ip_lo;
    logic [15:0] src_port;
    logic [15:0] dst_port;

    logic        is_tcp;
    logic        is_udp;
    logic        eligible;
    logic [7:0]  tcp_flags;
    logic [3:0]  flag_d;
    flow_key_t   key_d;

    // tkeep carries no information the parser needs.
    logic unused_tkeep;
    assign unused_tkeep = ^s_axis_tkeep;

    // Header eligibility and key/flag assembly, valid while beat 5 is on the bus.
    always_comb begin
        is_tcp    = (proto == IP_PROTO_TCP);
        is_udp    = (proto == IP_PROTO_UDP);
        eligible  = (eth_type == ETH_TYPE_IPV4) && (ver_ihl == IP_VER_IHL_5) &&
                    (frag == 14'd0) && (is_tcp || is_udp);
        tcp_flags = beat_byte(s_axis_tdata, 7);
        flag_d                 = 4'd0;
        flag_d[FLAG_TCP]       = is_tcp;
        flag_d[FLAG_UDP]       = is_udp;
        flag_d[FLAG_SYN]       = is_tcp && tcp_flags[1];
        flag_d[FLAG_FINRST]    = is_tcp && (tcp_flags[0] || tcp_flags[2]);
        key_d.src_ip   = src_ip;
        key_d.dst_ip   = {dst_ip_hi, dst_ip_lo};
        key_d.src_port = src_port;
        key_d.dst_port = dst_port;
    end

    // Parser state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            beat_cnt <= beat_cnt_d;
        end
    end

    // Next-state logic: frame framing, runt detection and key/drop decisions.
    always_comb begin
        state_d    = state;
        beat_cnt_d = beat_cnt;
        key_fire   = 1'b0;
        drop_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    if (s_axis_tlast) begin
                        drop_fire = 1'b1;
                    end else begin
                        state_d    = ST_HDR;
                        beat_cnt_d = 3'd1;
                    end
                end
            end
            ST_HDR: begin
                if (s_axis_tvalid) begin
                    if (beat_cnt == HDR_LAST_BEAT) begin
                        beat_cnt_d = '0;
                        key_fire   = eligible;
                        drop_fire  = !eligible;
                        state_d    = s_axis_tlast ? ST_IDLE : ST_SKIP;
                    end else if (s_axis_tlast) begin
                        beat_cnt_d = '0;
                        drop_fire  = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt + 3'd1;
                    end
                end
            end
            ST_SKIP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // Header field capture from beats 1..4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eth_type  <= '0;
            ver_ihl   <= '0;
            frag      <= '0;
            proto     <= '0;
            src_ip    <= '0;
            dst_ip_hi <= '0;
            dst_ip_lo <= '0;
            src_port  <= '0;
            dst_port  <= '0;
        end else if ((state == ST_HDR) && s_axis_tvalid) begin
            case (beat_cnt)
                3'd1: begin
                    eth_type <= {beat_byte(s_axis_tdata, 4), beat_byte(s_axis_tdata, 5)};
                    ver_ihl  <= beat_byte(s_axis_tdata, 6);
                end
                3'd2: begin
                    frag  <= {s_axis_tdata[37:32], beat_byte(s_axis_tdata, 5)};
                    proto <= beat_byte(s_axis_tdata, 7);
                end
                3'd3: begin
                    src_ip    <= {beat_byte(s_axis_tdata, 2), beat_byte(s_axis_tdata, 3),
                                  beat_byte(s_axis_tdata, 4), beat_byte(s_axis_tdata, 5)};
                    dst_ip_hi <= {beat_byte(s_axis_tdata, 6), beat_byte(s_axis_tdata, 7)};
                end
                3'd4: begin
                    dst_ip_lo <= {beat_byte(s_axis_tdata, 0), beat_byte(s_axis_tdata, 1)};
                    src_port  <= {beat_byte(s_axis_tdata, 2), beat_byte(s_axis_tdata, 3)};
                    dst_port  <= {beat_byte(s_axis_tdata, 4), beat_byte(s_axis_tdata, 5)};
                end
                default: ;
            endcase
        end
    end

    // Key strobe towards db_top; key/flag hold until the next strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid <= 1'b0;
            in_key   <= '0;
            in_flag  <= '0;
        end else begin
            in_valid <= key_fire;
            if (key_fire) begin
                in_key  <= KEY_SIZE'(key_d);
                in_flag <= FLAG_SIZE'(flag_d);
            end
        end
    end

    // Frame statistics, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_key_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (key_fire) begin
                stat_key_cnt <= stat_key_cnt + CNT_WIDTH'(1);
            end
            if (drop_fire) begin
                stat_drop_cnt <= stat_drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_eth_key_extract.sv
// Self-checking bench for eth_key_extract: table of frames with expected
// keys, a scoreboard queue of expected strobes, and a mid-frame reset case.
module tb_eth_key_extract;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic [95:0] in_key;
    logic [3:0]  in_flag;
    logic        in_valid;
    logic [31:0] stat_key_cnt;
    logic [31:0] stat_drop_cnt;

    always #5 clk = ~clk;

    eth_key_extract #(
        .KEY_SIZE  (96),
        .FLAG_SIZE (4),
        .CNT_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .in_key        (in_key),
        .in_flag       (in_flag),
        .in_valid      (in_valid),
        .stat_key_cnt  (stat_key_cnt),
        .stat_drop_cnt (stat_drop_cnt)
    );

    typedef struct {
        logic [15:0] etype;
        logic [7:0]  vihl;
        logic [15:0] frag;
        logic [7:0]  proto;
        logic [31:0] sip;
        logic [31:0] dip;
        logic [15:0] sp;
        logic [15:0] dp;
        logic [7:0]  tfl;
        int          len;
        bit          gaps;
        bit          settle;
        bit          ek;
        logic [95:0] key;
        logic [3:0]  flag;
    } vec_t;

    typedef struct {
        logic [95:0] key;
        logic [3:0]  flag;
        int          cyc;
    } exp_t;

    localparam int NVEC = 17;

    vec_t        vecs [NVEC];
    exp_t        sb [$];
    exp_t        mon_e;
    logic [7:0]  fb [0:127];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          exp_key_cnt = 0;
    int          exp_drop_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] etype, input logic [7:0] vihl,
                                input logic [15:0] frag, input logic [7:0] proto,
                                input logic [31:0] sip, input logic [31:0] dip,
                                input logic [15:0] sp, input logic [15:0] dp,
                                input logic [7:0] tfl, input int len, input bit gaps,
                                input bit settle, input bit ek, input logic [95:0] key,
                                input logic [3:0] flag);
        vec_t v;
        v.etype = etype; v.vihl = vihl; v.frag = frag; v.proto = proto;
        v.sip = sip; v.dip = dip; v.sp = sp; v.dp = dp; v.tfl = tfl;
        v.len = len; v.gaps = gaps; v.settle = settle; v.ek = ek;
        v.key = key; v.flag = flag;
        return v;
    endfunction

    // Scoreboard consumer: every strobe must match the oldest expected key.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && in_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_in_valid", 96'(1), 96'(0));
            end else begin
                mon_e = sb.pop_front();
                check("key", in_key, mon_e.key);
                check("flag", 96'(in_flag), 96'(mon_e.flag));
                check("strobe_cycle", 96'(cyc), 96'(mon_e.cyc));
            end
        end
    end

    task automatic build(input vec_t v);
        for (int i = 0; i < 128; i++) fb[i] = 8'((i * 7 + 3) & 255);
        fb[12] = v.etype[15:8]; fb[13] = v.etype[7:0];
        fb[14] = v.vihl;
        fb[20] = v.frag[15:8];  fb[21] = v.frag[7:0];
        fb[23] = v.proto;
        fb[26] = v.sip[31:24]; fb[27] = v.sip[23:16]; fb[28] = v.sip[15:8]; fb[29] = v.sip[7:0];
        fb[30] = v.dip[31:24]; fb[31] = v.dip[23:16]; fb[32] = v.dip[15:8]; fb[33] = v.dip[7:0];
        fb[34] = v.sp[15:8];   fb[35] = v.sp[7:0];
        fb[36] = v.dp[15:8];   fb[37] = v.dp[7:0];
        fb[47] = v.tfl;
    endtask

    task automatic put_beat(input int b, input int len);
        int rem;
        logic [8:0] km;
        for (int k = 0; k < 8; k++) s_axis_tdata[8*k +: 8] = fb[8*b + k];
        rem = len - 8 * b;
        km = (9'd1 << rem) - 9'd1;
        s_axis_tlast  = (rem <= 8);
        s_axis_tkeep  = (rem <= 8) ? km[7:0] : 8'hFF;
        s_axis_tvalid = 1'b1;
    endtask

    task automatic drive_beat(input int b, input int len);
        put_beat(b, len);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send(input vec_t v);
        int nb;
        exp_t e;
        build(v);
        nb = (v.len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            if (v.gaps && b > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            if (b == 5 && v.ek) begin
                e.key = v.key; e.flag = v.flag; e.cyc = cyc + 1;
                sb.push_back(e);
                exp_key_cnt++;
            end
            drive_beat(b, v.len);
        end
        if (!v.ek) exp_drop_cnt++;
    endtask

    task automatic settle_check(input int idx);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check($sformatf("key_cnt_after_%0d", idx), 96'(stat_key_cnt), 96'(exp_key_cnt));
        check($sformatf("drop_cnt_after_%0d", idx), 96'(stat_drop_cnt), 96'(exp_drop_cnt));
        check($sformatf("pending_keys_after_%0d", idx), 96'(sb.size()), 96'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = mk(16'h0800, 8'h45, 16'h0000, 8'd6,  32'h0A000001, 32'h0A000002, 16'd1234, 16'd80,
                      8'h02, 64, 0, 1, 1, 96'h0A000001_0A000002_04D2_0050, 4'b0101);
        vecs[1]  = mk(16'h0800, 8'h45, 16'h0000, 8'd17, 32'hC0A80101, 32'hC0A80109, 16'd53, 16'd5000,
                      8'hFF, 64, 0, 1, 1, 96'hC0A80101_C0A80109_0035_1388, 4'b0010);
        vecs[2]  = mk(16'h0806, 8'h45, 16'h0000, 8'd6,  32'h01010101, 32'h02020202, 16'd1, 16'd2,
                      8'h02, 64, 0, 0, 0, '0, '0);
        vecs[3]  = mk(16'h0800, 8'h46, 16'h0000, 8'd6,  32'h01010101, 32'h02020202, 16'd1, 16'd2,
                      8'h02, 64, 0, 0, 0, '0, '0);
        vecs[4]  = mk(16'h0800, 8'h45, 16'h00B9, 8'd6,  32'h01010101, 32'h02020202, 16'd1, 16'd2,
                      8'h02, 64, 0, 1, 0, '0, '0);
        vecs[5]  = mk(16'h0800, 8'h45, 16'h0000, 8'd6,  32'h0A000001, 32'h0A000002, 16'd1, 16'd2,
                      8'h02, 40, 0, 0, 0, '0, '0);
        vecs[6]  = mk(16'h0800, 8'h45, 16'h0000, 8'd6,  32'h0A000003, 32'h0A000004, 16'd8080, 16'd50000,
                      8'h11, 64, 0, 1, 1, 96'h0A000003_0A000004_1F90_C350, 4'b1001);
        vecs[7]  = mk(16'h0800, 8'h45, 16'h0000, 8'd6,  32'h01020304, 32'h05060708, 16'h0001, 16'hFFFF,
                      8'h04, 64, 0, 0, 1, 96'h01020304_05060708_0001_FFFF, 4'b1001);
        vecs[8]  = mk(16'h0800, 8'h45, 16'h0000, 8'd6,  32'hAC100001, 32'hAC100002, 16'h0016, 16'h1000,
                      8'h07, 64, 0, 1, 1, 96'hAC100001_AC100002_0016_1000, 4'b1101);
        vecs[9]  = mk(16'h0800, 8'h45, 16'h0000, 8'd6,  32'h11111111, 32'h22222222, 16'h3333, 16'h4444,
                      8'h10, 64, 1, 0, 1, 96'h11111111_22222222_3333_4444, 4'b0001);
        vecs[10] = mk(16'h0800, 8'h45, 16'h0000, 8'd17, 32'h0A0A0A0A, 32'h0B0B0B0B, 16'h0102, 16'h0304,
                      8'h02, 64, 1, 1, 1, 96'h0A0A0A0A_0B0B0B0B_0102_0304, 4'b0010);
        vecs[11] = mk(16'h0800, 8'h45, 16'h0000, 8'd6,  32'hC0000201, 32'hC0000202, 16'h1000, 16'h2000,
                      8'h02, 48, 0, 0, 1, 96'hC0000201_C0000202_1000_2000, 4'b0101);
        vecs[12] = mk(16'h0800, 8'h45, 16'h4000, 8'd17, 32'h08080808, 32'h01010101, 16'h0035, 16'hD431,
                      8'h00, 60, 0, 1, 1, 96'h08080808_01010101_0035_D431, 4'b0010);
        vecs[13] = mk(16'h0800, 8'h45, 16'h2000, 8'd6,  32'h01010101, 32'h02020202, 16'd1, 16'd2,
                      8'h02, 64, 0, 0, 0, '0, '0);
        vecs[14] = mk(16'h0800, 8'h45, 16'h0000, 8'd1,  32'h01010101, 32'h02020202, 16'd1, 16'd2,
                      8'h02, 64, 0, 0, 0, '0, '0);
        vecs[15] = mk(16'h8100, 8'h45, 16'h0000, 8'd6,  32'h01010101, 32'h02020202, 16'd1, 16'd2,
                      8'h02, 64, 0, 0, 0, '0, '0);
        vecs[16] = mk(16'h0800, 8'h45, 16'h0000, 8'd6,  32'h01010101, 32'h02020202, 16'd1, 16'd2,
                      8'h02, 8, 0, 1, 0, '0, '0);

        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_valid", 96'(in_valid), 96'(0));
        check("reset_in_key", in_key, 96'(0));
        check("reset_in_flag", 96'(in_flag), 96'(0));
        check("reset_key_cnt", 96'(stat_key_cnt), 96'(0));
        check("reset_drop_cnt", 96'(stat_drop_cnt), 96'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i]);
            if (vecs[i].settle) settle_check(i);
        end

        // Reset asserted while beat 3 of an eligible frame is on the bus.
        build(vecs[6]);
        drive_beat(0, 64);
        drive_beat(1, 64);
        drive_beat(2, 64);
        put_beat(3, 64);
        rst_n = 1'b0;
        exp_key_cnt  = 0;
        exp_drop_cnt = 0;
        @(negedge clk);
        check("midreset_in_valid", 96'(in_valid), 96'(0));
        check("midreset_in_key", in_key, 96'(0));
        check("midreset_in_flag", 96'(in_flag), 96'(0));
        check("midreset_key_cnt", 96'(stat_key_cnt), 96'(0));
        check("midreset_drop_cnt", 96'(stat_drop_cnt), 96'(0));
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(vecs[0]);
        settle_check(100);

        check("final_pending_keys", 96'(sb.size()), 96'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
